pc_int_sequencer: RTL and testbench
===================================

Name: pc_int_sequencer

Overview:
- Parametrised program-counter and flag/interrupt sequencer for the CPU core.
- Owns the PC register and the 8-bit flag register {V,C,Z,S,INT,FI,FO,RES}.
- Provides vectored entry and return for N_IRQ prioritised interrupt channels, with PC/flag save and restore.
- Sits between Control/ALU and instruction memory; drives instruction_address directly.

Parameters:
WIDTH, 32, PC and target width
N_IRQ, 4, number of interrupt request lines (1..16)
VEC_BASE, 32'h0000_0100, address of channel 0 handler
VEC_STRIDE, 4, address distance between consecutive channel vectors
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
step  input  1  instruction retired this cycle; PC may advance
pc_sel  input  2  0 = PC+1, 1 = branch_target, 2 = jump_target, 3 = return-from-interrupt
branch_target  input  WIDTH  branch destination
jump_target  input  WIDTH  register-jump destination
alu_flags  input  4  {V,C,Z,S} from ALU
flags_we  input  1  load alu_flags into flag[7:4] on step
ion  input  1  set INT (interrupt enable)
iof  input  1  clear INT
rfi  input  1  clear FI
rfo  input  1  clear FO
sfo  input  1  set FO
irq  input  N_IRQ  level interrupt requests
pc  output  WIDTH  current PC
flag_register  output  8  {V,C,Z,S,INT,FI,FO,RES}
stall  output  1  high during ENTRY; core must hold its instruction
int_ack  output  N_IRQ  one-hot, one-cycle pulse on entry
in_service  output  1  high in SERVICE
irq_id  output  4  channel currently or last serviced

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, flags=8'h00, pending=0, state RUN, stall=0, int_ack=0, in_service=0, irq_id=0, saved_pc=0, saved_flags=0. Reset mid-handler abandons the handler without restore.
- Pending: bit i sets on an irq[i] rising edge (2-FF-free, sampled each clk). It clears on the cycle int_ack[i] pulses. A rising edge coincident with its own ack stays set.
- Flag updates are applied only when step=1:
  - flags_we loads V,C,Z,S.
  - INT: iof wins over ion when both are asserted.
  - FO: rfo wins over sfo.
  - rfi clears FI.
  - RES is always 0.
- FSM states: RUN, ENTRY, SERVICE.
- RUN:
  - On step, compute next_pc per pc_sel; pc_sel=3 in RUN behaves as 0. Arithmetic wraps modulo 2^WIDTH.
  - If INT=1 and pending≠0 at a step: take the lowest-index pending channel k.
    - saved_pc = next_pc.
    - saved_flags = flags after this cycle's updates.
    - pc = VEC_BASE + k*VEC_STRIDE.
    - INT cleared, FI set, irq_id = k.
    - Go to ENTRY.
  - Otherwise pc = next_pc.
  - Without step, pc holds.
- ENTRY (exactly 1 cycle): stall=1, int_ack[k]=1, step ignored. Next state is SERVICE.
- SERVICE:
  - in_service=1.
  - step with pc_sel 0/1/2 advances normally.
  - step with pc_sel=3 restores pc=saved_pc and flags=saved_flags (INT returns to its pre-entry value, 1), then goes to RUN.
  - No nesting: pending requests wait. A request pending at return can be taken at the next step in RUN, never on the return step itself.
- Latency: the PC update is visible on the cycle after the step edge; the vector address is visible the cycle after the taking step.

Optional Feature:
- Macro IRQ_MASK_EN.
- Defined:
  - Adds ports mask_we (1) and mask_wdata (N_IRQ) and an N_IRQ-bit mask register, reset to all-ones.
  - Only pending & mask participates in arbitration; masked pending bits are retained.
  - A mask write takes effect on the next cycle.
- Undefined: no ports are added and all channels are always eligible.

Test Plan:
- Reset release, 5 steps with pc_sel=0 → pc = 0,1,2,3,4,5; flag_register=8'h00.
- pc=10, step, pc_sel=1, branch_target=0x40, flags_we, alu_flags=4'b0110 → pc=0x40, flag_register=8'h60.
- ion step, then irq=4'b1010 pulse, step at pc=7 → channel 1 taken: pc=0x104, stall 1 cycle, int_ack=4'b0010, FI=1, INT=0, irq_id=1; channel 3 stays pending.
- In SERVICE, step with pc_sel=3 → pc=8, INT=1, FI restored to 0; next step takes channel 3 → pc=0x10C.
- rst asserted while in SERVICE → immediate pc=0, flags=0, pending=0, in_service=0.
- IRQ_MASK_EN: mask=4'b1101, irq[1] pending, INT=1, step → no entry; write mask=4'b1111, step → entry to 0x104.

Source files
------------

// File: rtl/pc_int_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_int_sequencer_if
//  Purpose  : Bundle of the control, flag and interrupt signals exchanged
//             between the core (master) and the PC/interrupt sequencer
//             (slave).
//  Members  : step, pc_sel, branch_target, jump_target, alu_flags, flags_we,
//             ion, iof, rfi, rfo, sfo, irq          (master -> slave)
//             pc, flag_register, stall, int_ack, in_service, irq_id
//                                                   (slave -> master)
//             mask_we, mask_wdata (only with IRQ_MASK_EN defined)
//  Macro    : IRQ_MASK_EN adds the interrupt mask write port.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_int_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IRQ = 4
);
    logic                 step;
    logic [1:0]           pc_sel;
    logic [WIDTH-1:0]     branch_target;
    logic [WIDTH-1:0]     jump_target;
    logic [3:0]           alu_flags;
    logic                 flags_we;
    logic                 ion;
    logic                 iof;
    logic                 rfi;
    logic                 rfo;
    logic                 sfo;
    logic [N_IRQ-1:0]     irq;
    logic [WIDTH-1:0]     pc;
    logic [7:0]           flag_register;
    logic                 stall;
    logic [N_IRQ-1:0]     int_ack;
    logic                 in_service;
    logic [3:0]           irq_id;
`ifdef IRQ_MASK_EN
    logic                 mask_we;
    logic [N_IRQ-1:0]     mask_wdata;
`endif

    modport master (
`ifdef IRQ_MASK_EN
        output mask_we, mask_wdata,
`endif
        output step, pc_sel, branch_target, jump_target, alu_flags, flags_we,
        output ion, iof, rfi, rfo, sfo, irq,
        input  pc, flag_register, stall, int_ack, in_service, irq_id
    );

    modport slave (
`ifdef IRQ_MASK_EN
        input  mask_we, mask_wdata,
`endif
        input  step, pc_sel, branch_target, jump_target, alu_flags, flags_we,
        input  ion, iof, rfi, rfo, sfo, irq,
        output pc, flag_register, stall, int_ack, in_service, irq_id
    );
endinterface
`default_nettype wire

// File: rtl/pc_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_int_sequencer
//  Purpose  : Program counter and flag/interrupt sequencer. Owns the PC and
//             the flag register {V,C,Z,S,INT,FI,FO,RES}, and performs
//             vectored entry / return for N_IRQ prioritised interrupt lines
//             with PC and flag save/restore.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - pc_int_sequencer_if.slave (core controls, irq lines,
//                    pc / flag_register / stall / int_ack / in_service /
//                    irq_id outputs)
//  Macro    : IRQ_MASK_EN - adds an N_IRQ-bit mask register (reset to all
//             ones) written through bus.mask_we / bus.mask_wdata.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_int_sequencer #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      N_IRQ      = 4,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_0100),
    parameter int unsigned      VEC_STRIDE = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    pc_int_sequencer_if.slave bus
);

    // Flag register bit positions
    localparam int unsigned c_f_int = 3;
    localparam int unsigned c_f_fi  = 2;
    localparam int unsigned c_f_fo  = 1;

    localparam logic [1:0] c_st_run     = 2'd0;
    localparam logic [1:0] c_st_entry   = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [7:0]       r_flags;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_irq_q;
    logic [3:0]       r_irq_id;
    logic [WIDTH-1:0] r_saved_pc;
    logic [7:0]       r_saved_flags;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_ack;
    logic [N_IRQ-1:0] w_eligible;
    logic [3:0]       w_take_id;
    logic             w_take;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_vector;
    logic [7:0]       w_upd_flags;
    logic [7:0]       w_entry_flags;

    // ------------------------------------------------------------------------
    // Interrupt eligibility (optional mask)
    // ------------------------------------------------------------------------
`ifdef IRQ_MASK_EN
    logic [N_IRQ-1:0] r_mask;

    // Masked requests stay pending; they just cannot win arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '1;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
        end
    end

    assign w_eligible = r_pending & r_mask;
`else
    assign w_eligible = r_pending;
`endif

    // Level inputs are sampled directly; a 0->1 change between two
    // consecutive samples marks the channel pending.
    assign w_rise = bus.irq & ~r_irq_q;
    assign w_ack  = (r_state == c_st_entry) ? (N_IRQ'(1) << r_irq_id) : '0;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_take_id = 4'd0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_take_id = 4'(i);
            end
        end
    end

    assign w_take   = (r_state == c_st_run) && bus.step &&
                      r_flags[c_f_int] && (|w_eligible);
    assign w_vector = VEC_BASE + WIDTH'(VEC_STRIDE) * WIDTH'(w_take_id);

    // pc_sel=3 only means "return" in SERVICE; elsewhere it behaves as +1.
    always_comb begin
        case (bus.pc_sel)
            2'd1:    w_next_pc = bus.branch_target;
            2'd2:    w_next_pc = bus.jump_target;
            default: w_next_pc = r_pc + WIDTH'(1);
        endcase
    end

    // Flags as they would look after this step's updates.
    always_comb begin
        w_upd_flags = r_flags;
        if (bus.flags_we) begin
            w_upd_flags[7:4] = bus.alu_flags;
        end
        if (bus.iof) begin
            w_upd_flags[c_f_int] = 1'b0;
        end else if (bus.ion) begin
            w_upd_flags[c_f_int] = 1'b1;
        end
        if (bus.rfi) begin
            w_upd_flags[c_f_fi] = 1'b0;
        end
        if (bus.rfo) begin
            w_upd_flags[c_f_fo] = 1'b0;
        end else if (bus.sfo) begin
            w_upd_flags[c_f_fo] = 1'b1;
        end
        w_upd_flags[0] = 1'b0;
    end

    // On entry interrupts are disabled and FI marks "inside handler".
    assign w_entry_flags = {w_upd_flags[7:4], 1'b0, 1'b1, w_upd_flags[1], 1'b0};

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_run;
            r_pc          <= RESET_PC;
            r_flags       <= 8'h00;
            r_pending     <= '0;
            r_irq_q       <= '0;
            r_irq_id      <= 4'd0;
            r_saved_pc    <= '0;
            r_saved_flags <= 8'h00;
        end else begin
            r_irq_q   <= bus.irq;
            // A rise coincident with its own ack re-arms the channel.
            r_pending <= (r_pending & ~w_ack) | w_rise;

            case (r_state)
                c_st_run: begin
                    if (bus.step) begin
                        if (w_take) begin
                            r_saved_pc    <= w_next_pc;
                            r_saved_flags <= w_upd_flags;
                            r_pc          <= w_vector;
                            r_flags       <= w_entry_flags;
                            r_irq_id      <= w_take_id;
                            r_state       <= c_st_entry;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_flags <= w_upd_flags;
                        end
                    end
                end
                c_st_entry: begin
                    r_state <= c_st_service;
                end
                c_st_service: begin
                    if (bus.step) begin
                        if (bus.pc_sel == 2'd3) begin
                            r_pc    <= r_saved_pc;
                            r_flags <= r_saved_flags;
                            r_state <= c_st_run;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_flags <= w_upd_flags;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase
        end
    end

    assign bus.pc            = r_pc;
    assign bus.flag_register = r_flags;
    assign bus.stall         = (r_state == c_st_entry);
    assign bus.int_ack       = w_ack;
    assign bus.in_service    = (r_state == c_st_service);
    assign bus.irq_id        = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_pc_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_int_sequencer
//  Purpose  : Self-checking bench for pc_int_sequencer: directed vector
//             table, hand-written reset / mask sequences and a randomized
//             run compared against a behavioural reference model.
//  Macro    : IRQ_MASK_EN enables the mask sequence and random mask writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_int_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    pc_int_sequencer_if #(.WIDTH(32), .N_IRQ(4)) bus ();

    pc_int_sequencer #(
        .WIDTH      (32),
        .N_IRQ      (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        step;
        logic [1:0]  sel;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [3:0]  alu;
        logic        fwe, ion, iof, rfi, rfo, sfo;
        logic [3:0]  irq;
        logic [31:0] e_pc;
        logic [7:0]  e_flags;
        logic        e_stall;
        logic [3:0]  e_ack;
        logic        e_insvc;
        logic [3:0]  e_id;
    } vec_t;

    vec_t vecs [24];

    // Reference model state
    logic [31:0] m_pc, m_saved_pc;
    logic [7:0]  m_flags, m_saved_flags;
    logic [3:0]  m_pend, m_prev_irq, m_mask;
    bit          m_ack_due, m_in_handler;
    int          m_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.step = 1'b0; bus.pc_sel = 2'd0; bus.branch_target = '0; bus.jump_target = '0;
        bus.alu_flags = 4'h0; bus.flags_we = 1'b0; bus.ion = 1'b0; bus.iof = 1'b0;
        bus.rfi = 1'b0; bus.rfo = 1'b0; bus.sfo = 1'b0;
`ifdef IRQ_MASK_EN
        bus.mask_we = 1'b0; bus.mask_wdata = 4'h0;
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_saved_pc = 32'h0; m_flags = 8'h00; m_saved_flags = 8'h00;
        m_pend = 4'h0; m_prev_irq = 4'h0; m_mask = 4'hF;
        m_ack_due = 1'b0; m_in_handler = 1'b0; m_id = 0;
    endtask

    // Advances the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic [3:0]  ack, rise, elig;
        logic [31:0] np;
        logic [7:0]  nf;
        int          k;
        ack  = m_ack_due ? 4'(1 << m_id) : 4'h0;
        rise = bus.irq & ~m_prev_irq;
        if (m_ack_due) begin
            m_ack_due    = 1'b0;
            m_in_handler = 1'b1;
        end else if (bus.step) begin
            nf = m_flags;
            if (bus.flags_we) nf[7:4] = bus.alu_flags;
            if (bus.iof) nf[3] = 1'b0; else if (bus.ion) nf[3] = 1'b1;
            if (bus.rfi) nf[2] = 1'b0;
            if (bus.rfo) nf[1] = 1'b0; else if (bus.sfo) nf[1] = 1'b1;
            if (m_in_handler && bus.pc_sel == 2'd3) begin
                m_pc         = m_saved_pc;
                m_flags      = m_saved_flags;
                m_in_handler = 1'b0;
            end else begin
                if (bus.pc_sel == 2'd1)      np = bus.branch_target;
                else if (bus.pc_sel == 2'd2) np = bus.jump_target;
                else                         np = m_pc + 32'd1;
                elig = m_pend & m_mask;
                if (!m_in_handler && m_flags[3] && elig != 4'h0) begin
                    k = 0;
                    while (!elig[k]) k++;
                    m_saved_pc    = np;
                    m_saved_flags = nf;
                    m_pc          = 32'h100 + 32'(4 * k);
                    nf[3]         = 1'b0;
                    nf[2]         = 1'b1;
                    m_id          = k;
                    m_ack_due     = 1'b1;
                end else begin
                    m_pc = np;
                end
                m_flags = nf;
            end
        end
        m_pend     = (m_pend & ~ack) | rise;
        m_prev_irq = bus.irq;
`ifdef IRQ_MASK_EN
        if (bus.mask_we) m_mask = bus.mask_wdata;
`endif
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d pc", cyc),         bus.pc,            m_pc);
        chk($sformatf("rnd%0d flags", cyc),      bus.flag_register, m_flags);
        chk($sformatf("rnd%0d stall", cyc),      bus.stall,         m_ack_due);
        chk($sformatf("rnd%0d int_ack", cyc),    bus.int_ack,       m_ack_due ? 4'(1 << m_id) : 4'h0);
        chk($sformatf("rnd%0d in_service", cyc), bus.in_service,    m_in_handler);
        chk($sformatf("rnd%0d irq_id", cyc),     bus.irq_id,        4'(m_id));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        bus.irq  = 4'h0;
        idle_inputs();

        // step sel bt jt alu fwe ion iof rfi rfo sfo irq | pc flags stall ack insvc id
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h1,        8'h00, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h2,        8'h00, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h3,        8'h00, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h4,        8'h00, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h5,        8'h00, 0, 0, 0, 0};
        vecs[5]  = '{1, 2, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 8'h00, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h0,        8'h00, 0, 0, 0, 0};
        vecs[7]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h1,        8'h00, 0, 0, 0, 0};
        vecs[8]  = '{1, 2, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0,   32'hA,        8'h00, 0, 0, 0, 0};
        vecs[9]  = '{1, 1, 32'h40, 0, 4'b0110, 1, 0, 0, 0, 0, 0, 0, 32'h40,  8'h60, 0, 0, 0, 0};
        vecs[10] = '{1, 2, 0, 32'h7, 0, 0, 1, 0, 0, 0, 0, 0,   32'h7,        8'h68, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 32'h7,        8'h68, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h7,        8'h68, 0, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h104,      8'h64, 1, 4'b0010, 0, 1};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h104,      8'h64, 0, 0, 1, 1};
        vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h105,      8'h64, 0, 0, 1, 1};
        vecs[16] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h8,        8'h68, 0, 0, 0, 1};
        vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h10C,      8'h64, 1, 4'b1000, 0, 3};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h10C,      8'h64, 0, 0, 1, 3};
        vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,       32'h10D,      8'h66, 0, 0, 1, 3};
        vecs[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,       32'h10E,      8'h64, 0, 0, 1, 3};
        vecs[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,       32'h10F,      8'h60, 0, 0, 1, 3};
        vecs[22] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       32'h9,        8'h68, 0, 0, 0, 3};
        vecs[23] = '{1, 0, 0, 0, 4'b1001, 1, 1, 1, 0, 0, 0, 0, 32'hA,        8'h90, 0, 0, 0, 3};

        // Reset state
        tick();
        tick();
        chk("reset pc", bus.pc, 32'h0);
        chk("reset flags", bus.flag_register, 8'h00);
        chk("reset stall", bus.stall, 1'b0);
        chk("reset int_ack", bus.int_ack, 4'h0);
        chk("reset in_service", bus.in_service, 1'b0);
        chk("reset irq_id", bus.irq_id, 4'h0);
        #2 rst = 1'b1;

        // Directed vector table, one row per clock
        for (int i = 0; i < 24; i++) begin
            bus.step = vecs[i].step; bus.pc_sel = vecs[i].sel;
            bus.branch_target = vecs[i].bt; bus.jump_target = vecs[i].jt;
            bus.alu_flags = vecs[i].alu; bus.flags_we = vecs[i].fwe;
            bus.ion = vecs[i].ion; bus.iof = vecs[i].iof; bus.rfi = vecs[i].rfi;
            bus.rfo = vecs[i].rfo; bus.sfo = vecs[i].sfo; bus.irq = vecs[i].irq;
            tick();
            chk($sformatf("vec%0d pc", i),         bus.pc,            vecs[i].e_pc);
            chk($sformatf("vec%0d flags", i),      bus.flag_register, vecs[i].e_flags);
            chk($sformatf("vec%0d stall", i),      bus.stall,         vecs[i].e_stall);
            chk($sformatf("vec%0d int_ack", i),    bus.int_ack,       vecs[i].e_ack);
            chk($sformatf("vec%0d in_service", i), bus.in_service,    vecs[i].e_insvc);
            chk($sformatf("vec%0d irq_id", i),     bus.irq_id,        vecs[i].e_id);
        end

        // Reset in the middle of a handler abandons it without restore
        idle_inputs();
        bus.step = 1'b1; bus.ion = 1'b1;
        tick();
        chk("pre-rst pc", bus.pc, 32'hB);
        idle_inputs();
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        tick();
        bus.step = 1'b1;
        tick();
        chk("pre-rst vector", bus.pc, 32'h100);
        chk("pre-rst ack", bus.int_ack, 4'b0001);
        bus.step = 1'b0;
        tick();
        chk("pre-rst in_service", bus.in_service, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("midrst pc", bus.pc, 32'h0);
        chk("midrst flags", bus.flag_register, 8'h00);
        chk("midrst in_service", bus.in_service, 1'b0);
        chk("midrst irq_id", bus.irq_id, 4'h0);
        #1 rst = 1'b1;
        bus.step = 1'b1; bus.ion = 1'b1;
        tick();
        chk("postrst pc", bus.pc, 32'h1);
        chk("postrst flags", bus.flag_register, 8'h08);
        bus.ion = 1'b0;
        tick();
        chk("postrst no-take pc", bus.pc, 32'h2);
        chk("postrst no-take stall", bus.stall, 1'b0);

`ifdef IRQ_MASK_EN
        // Masked pending request is held back until the mask opens
        idle_inputs();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1101;
        tick();
        bus.mask_we = 1'b0; bus.irq = 4'b0010;
        tick();
        bus.irq = 4'b0000;
        tick();
        bus.step = 1'b1;
        tick();
        chk("mask blocked pc", bus.pc, 32'h3);
        chk("mask blocked stall", bus.stall, 1'b0);
        bus.step = 1'b0; bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
        tick();
        bus.mask_we = 1'b0; bus.step = 1'b1;
        tick();
        chk("mask open pc", bus.pc, 32'h104);
        chk("mask open ack", bus.int_ack, 4'b0010);
        bus.step = 1'b0;
        tick();
        bus.step = 1'b1; bus.pc_sel = 2'd3;
        tick();
        chk("mask return pc", bus.pc, 32'h4);
        chk("mask return flags", bus.flag_register, 8'h08);
`endif

        // Randomized run against the reference model
        idle_inputs();
        bus.irq = 4'h0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.step          = ($urandom_range(0, 9) < 7);
            bus.pc_sel        = 2'($urandom_range(0, 3));
            bus.branch_target = $urandom;
            bus.jump_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.alu_flags     = 4'($urandom_range(0, 15));
            bus.flags_we      = 1'($urandom_range(0, 1));
            bus.ion           = ($urandom_range(0, 2) == 0);
            bus.iof           = ($urandom_range(0, 7) == 0);
            bus.rfi           = ($urandom_range(0, 5) == 0);
            bus.rfo           = ($urandom_range(0, 5) == 0);
            bus.sfo           = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) bus.irq[b] = ~bus.irq[b];
            end
`ifdef IRQ_MASK_EN
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = 4'($urandom_range(0, 15));
`endif
            model_edge();
            tick();
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
